// File: rtl/uart_rx_mmap_if.sv
// rtl/uart_rx_mmap_if.sv - memory map bus bundle for uart_rx_mmap
// Purpose: groups the 2-bit-address memory map bus so it can be passed as one port.
// Signals:
//   i_memAddr    register select (00 CTRL, 01 BAUD, 10 STATUS, 11 DATA)
//   i_memDataIn  16-bit write data
//   i_memWrEn    write strobe, applies at the clock edge
//   i_memRdEn    read strobe (pops the FIFO at DATA)
//   o_memDataOut combinational read data for i_memAddr
// Modports: master (bus driver), slave (register block).
interface uart_rx_mmap_if;
    logic [1:0]  i_memAddr;
    logic [15:0] i_memDataIn;
    logic        i_memWrEn;
    logic        i_memRdEn;
    logic [15:0] o_memDataOut;

    modport master (
        output i_memAddr,
        output i_memDataIn,
        output i_memWrEn,
        output i_memRdEn,
        input  o_memDataOut
    );

    modport slave (
        input  i_memAddr,
        input  i_memDataIn,
        input  i_memWrEn,
        input  i_memRdEn,
        output o_memDataOut
    );
endinterface

// File: rtl/uart_rx_mmap.sv
// rtl/uart_rx_mmap.sv - memory-mapped 8N1 UART receiver with byte FIFO
// Purpose: synchronises the GPIO RX line, deserialises 8N1 frames at a programmable
// divisor, queues bytes in a FIFO and pulses an interrupt per received byte.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
// Ports:
//   i_clk     system clock, all state on the rising edge
//   i_rst     synchronous active-high reset
//   bus       memory map bus (slave modport of uart_rx_mmap_if)
//   i_uartRX  asynchronous serial line, idle high
//   o_intRX   registered one-cycle interrupt pulse per received byte
module uart_rx_mmap #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_rx_mmap_if.slave bus,
    input  logic          i_uartRX,
    output logic          o_intRX
);
    localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned   CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
    localparam int unsigned   CTRL_W  = 4;
`else
    localparam int unsigned   CTRL_W  = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic              rx_meta_q, rx_meta_d;
    logic              rx_sync_q, rx_sync_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       baud_q, baud_d;
    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       div_q, div_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        fifo_q [FIFO_DEPTH];
    logic [7:0]        fifo_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              ferr_q, ferr_d;
    logic              int_q, int_d;
`ifdef UART_RX_PARITY_EN
    logic              perr_q, perr_d;
    logic              par_bad_q, par_bad_d;
`endif

    logic        rx_s;
    logic        en;
    logic        ie;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        perr_bit;
    logic [15:0] baud_eff;
    logic [15:0] half_m1;
    logic [15:0] rdata;

    assign rx_s     = rx_sync_q;
    assign en       = ctrl_q[0];
    assign ie       = ctrl_q[1];
    // Divisors below 2 would make the start-bit midpoint negative.
    assign baud_eff = (baud_q < 16'd2) ? 16'd2 : baud_q;
    assign half_m1  = (div_q >> 1) - 16'd1;
`ifdef UART_RX_PARITY_EN
    assign perr_bit = perr_q;
`else
    assign perr_bit = 1'b0;
`endif

    always_comb begin
        rx_meta_d = i_uartRX;
        rx_sync_d = rx_meta_q;
        ctrl_d    = ctrl_q;
        baud_d    = baud_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
        par_bad_d = par_bad_q;
`endif
        push_req  = 1'b0;
        push_ok   = 1'b0;
        pop       = bus.i_memRdEn && (bus.i_memAddr == 2'b11) && (count_q != '0);

        // Register writes; sticky-flag clears come before FSM sets so a new error wins.
        if (bus.i_memWrEn) begin
            case (bus.i_memAddr)
                2'b00: ctrl_d = bus.i_memDataIn[CTRL_W-1:0];
                2'b01: baud_d = bus.i_memDataIn;
                2'b10: begin
                    if (bus.i_memDataIn[2]) ovr_d  = 1'b0;
                    if (bus.i_memDataIn[3]) ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    if (bus.i_memDataIn[4]) perr_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        if (!en) begin
            // Disabling abandons any partial frame.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d   = S_START;
                        cnt_d     = '0;
                        div_d     = baud_eff;
                        bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (cnt_q == half_m1) begin
                        cnt_d   = '0;
                        state_d = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_d     = '0;
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ctrl_q[2] ? S_PARITY : S_STOP;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_d   = '0;
                        state_d = S_STOP;
                        // Total ones including the parity bit: even for EVEN, odd for ODD.
                        if ((^shift_q ^ rx_s) != ctrl_q[3]) begin
                            par_bad_d = 1'b1;
                            perr_d    = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            push_req = !par_bad_q;
`else
                            push_req = 1'b1;
`endif
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        if (push_req) begin
            if ((count_q != DEPTH_C) || pop) begin
                fifo_d[wr_ptr_q] = shift_q;
                wr_ptr_d         = wr_ptr_q + 1'b1;
                push_ok          = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + CW'(push_ok) - CW'(pop);
        int_d   = push_ok && ie;
    end

    always_comb begin
        rdata = '0;
        case (bus.i_memAddr)
            2'b00: rdata[CTRL_W-1:0] = ctrl_q;
            2'b01: rdata = baud_q;
            2'b10: rdata = {3'b000, 5'(count_q), 3'b000, perr_bit, ferr_q, ovr_q,
                            (count_q == DEPTH_C), (count_q != '0)};
            default: if (count_q != '0) rdata = {8'h00, fifo_q[rd_ptr_q]};
        endcase
    end

    assign bus.o_memDataOut = rdata;
    assign o_intRX          = int_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            ctrl_q    <= '0;
            baud_q    <= DEFAULT_DIV;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 16'd2;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            int_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            ctrl_q    <= ctrl_d;
            baud_q    <= baud_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            int_q     <= int_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Storage only; occupancy is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        fifo_q <= fifo_d;
    end
endmodule
